// File: rtl/carga_contador_bcd_pkg.sv
// Shared types and constants for the BCD entry / countdown block.
// State encoding, digit limits and the saturation ceiling helper.
package carga_contador_bcd_pkg;

    typedef enum logic [1:0] {
        EDIT    = 2'd0,
        CONVERT = 2'd1,
        RUN     = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam int         TEN       = 10;

    function automatic int cmax(input int n);
        return (1 << n) - 1;
    endfunction

endpackage

// File: rtl/carga_contador_bcd_detector_flanco.sv
// Single-bit rising-edge detector; input is already synchronous and debounced.
module detector_flanco (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic edge_o
);

    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= sig_i;
    end

    assign edge_o = sig_i & ~prev_q;

endmodule

// File: rtl/carga_contador_bcd.sv
// Two-digit BCD entry, iterative BCD-to-binary conversion with clamping,
// then tick-driven countdown to zero.
//
// state   | meaning
// EDIT    | operator edits digits; count holds
// CONVERT | acc += 10 once per tens unit
// RUN     | count decrements on tick; load aborts
// DONE    | count reached zero; load returns to EDIT
module carga_contador_bcd
    import carga_contador_bcd_pkg::*;
#(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         sel,
    input  logic         load,
    input  logic         tick,
    output logic [3:0]   d0,
    output logic [3:0]   d1,
    output logic         sel_digit,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         done,
    output logic         sat
);

    localparam int           AW     = N + 2;
    localparam logic [AW-1:0] CMAX_W = AW'(cmax(N));

    state_t         state_q, state_d;
    logic [3:0]     d0_q, d0_d, d1_q, d1_d, k_q, k_d;
    logic           sel_q, sel_d, done_q, done_d, sat_q, sat_d;
    logic [N-1:0]   count_q, count_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic           inc_e, sel_e, load_e;

    detector_flanco u_det_inc  (.clk(clk), .rst(rst), .sig_i(inc),  .edge_o(inc_e));
    detector_flanco u_det_sel  (.clk(clk), .rst(rst), .sig_i(sel),  .edge_o(sel_e));
    detector_flanco u_det_load (.clk(clk), .rst(rst), .sig_i(load), .edge_o(load_e));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EDIT;
            d0_q    <= '0;
            d1_q    <= '0;
            k_q     <= '0;
            sel_q   <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
            count_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            k_q     <= k_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
            count_q <= count_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        k_d     = k_q;
        sel_d   = sel_q;
        done_d  = done_q;
        sat_d   = sat_q;
        count_d = count_q;
        acc_d   = acc_q;
        case (state_q)
            EDIT: begin
                // load beats sel beats inc; losers in the same cycle are dropped
                if (load_e) begin
                    sat_d   = 1'b0;
                    acc_d   = AW'(d0_q);
                    k_d     = '0;
                    state_d = CONVERT;
                end else if (sel_e) begin
                    sel_d = ~sel_q;
                end else if (inc_e) begin
                    if (!sel_q) d0_d = (d0_q == DIGIT_MAX) ? 4'd0 : d0_q + 4'd1;
                    else        d1_d = (d1_q == DIGIT_MAX) ? 4'd0 : d1_q + 4'd1;
                end
            end
            CONVERT: begin
                if (k_q < d1_q) begin
                    acc_d = acc_q + AW'(TEN);
                    k_d   = k_q + 4'd1;
                end else begin
                    state_d = RUN;
                    if (acc_q > CMAX_W) begin
                        count_d = N'(cmax(N));
                        sat_d   = 1'b1;
                    end else begin
                        count_d = acc_q[N-1:0];
                        sat_d   = 1'b0;
                    end
                end
            end
            RUN: begin
                if (load_e) begin
                    state_d = EDIT;
                end else if (count_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (tick) begin
                    count_d = count_q - N'(1);
                end
            end
            DONE: begin
                count_d = '0;
                if (load_e) begin
                    state_d = EDIT;
                    done_d  = 1'b0;
                end
            end
            default: state_d = EDIT;
        endcase
    end

    assign d0        = d0_q;
    assign d1        = d1_q;
    assign sel_digit = sel_q;
    assign count     = count_q;
    assign busy      = (state_q == CONVERT) || (state_q == RUN);
    assign done      = done_q;
    assign sat       = sat_q;

endmodule
